// File: rtl/serial_add16_pkg.sv
// Shared definitions for the digit-serial 16-bit adder: FSM states,
// digit width and the default operand length in digits.
package serial_add16_pkg;

   localparam int unsigned DIGIT_W         = 4;
   localparam int unsigned NIBBLES_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add16_add4_cin.sv
// One-digit adder with carry in/out, built as a ripple of full adders.
module add4_cin
   import serial_add16_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] sum,
   output logic               cout
);

   logic [DIGIT_W:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < DIGIT_W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[DIGIT_W];

endmodule

// File: rtl/serial_add16.sv
// Digit-serial unsigned adder: one 4-bit digit per cycle, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_add16
   import serial_add16_pkg::*;
#(
   parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DIGIT_W*NIBBLES-1:0]   in_a,
   input  logic [DIGIT_W*NIBBLES-1:0]   in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DIGIT_W*NIBBLES-1:0]   out_sum,
   output logic                         out_carry,
   output logic                         busy
);

   localparam int unsigned W     = DIGIT_W * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t             state;
   state_t             state_nx;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic               carry_q;
   logic [IDX_W-1:0]   idx;
   logic [DIGIT_W-1:0] dig_a;
   logic [DIGIT_W-1:0] dig_b;
   logic [DIGIT_W-1:0] dig_s;
   logic               dig_c;
   logic               accept;

   assign accept = in_valid && (state == IDLE);
   assign dig_a  = a_q[idx*DIGIT_W +: DIGIT_W];
   assign dig_b  = b_q[idx*DIGIT_W +: DIGIT_W];

   add4_cin u_add4 (
      .a    (dig_a),
      .b    (dig_b),
      .cin  (carry_q),
      .sum  (dig_s),
      .cout (dig_c)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)        state_nx = RUN;
         RUN:     if (idx == LAST_IDX) state_nx = DONE;
         DONE:    if (out_ready)       state_nx = IDLE;
         default:                      state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // sum_q is only written digit by digit in RUN, so the previous result
   // stays visible in IDLE until the next operation overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
      end else if (accept) begin
         a_q     <= in_a;
         b_q     <= in_b;
         carry_q <= 1'b0;
         idx     <= '0;
      end else if (state == RUN) begin
         sum_q[idx*DIGIT_W +: DIGIT_W] <= dig_s;
         carry_q                       <= dig_c;
         idx                           <= idx + IDX_W'(1);
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign out_sum   = sum_q;
   assign out_carry = carry_q;

endmodule

// File: tb/tb_serial_add16.sv
// Self-checking bench for serial_add16: transaction-level reference model,
// directed corner cases and a randomised handshake run.
module tb_serial_add16;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = 4 * NIBBLES;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_carry;
   logic         busy;

   serial_add16 #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted pair yields a+b after NIBBLES edges,
   // then the result is held until taken; the last result persists.
   logic         m_pend;
   logic         m_valid;
   int           m_left;
   logic [W-1:0] m_sum;
   logic         m_carry;
   logic [W:0]   m_next;
   int           n_acc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend  = 1'b0;
         m_valid = 1'b0;
         m_left  = 0;
         m_sum   = '0;
         m_carry = 1'b0;
      end else if (m_pend) begin
         m_left--;
         if (m_left == 0) begin
            m_pend  = 1'b0;
            m_valid = 1'b1;
            {m_carry, m_sum} = m_next;
         end
      end else if (m_valid) begin
         if (out_ready) m_valid = 1'b0;
      end else if (in_valid) begin
         m_next = {1'b0, in_a} + {1'b0, in_b};
         m_pend = 1'b1;
         m_left = NIBBLES;
         n_acc++;
      end
   end

   int           ncyc = 0;
   logic [W:0]   res_q[$];
   int           dut_acc_q[$];

   always @(negedge clk) begin
      ncyc++;
      check("in_ready", 32'(in_ready), 32'(!(m_pend || m_valid)));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_pend || m_valid));
      if (!m_pend) begin
         check("out_sum", 32'(out_sum), 32'(m_sum));
         check("out_carry", 32'(out_carry), 32'(m_carry));
      end
      if (out_valid && out_ready) res_q.push_back({out_carry, out_sum});
      if (in_valid && in_ready) dut_acc_q.push_back(ncyc);
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int k;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept_timeout", 32'(k < 50), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
   endtask

   // Called #1 after the accepting edge; out_valid must be visible after
   // the NIBBLES-th following edge.
   task automatic finish_op(input logic [W-1:0] es, input logic ec, input int hold);
      int lat;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(NIBBLES));
      check("lit_sum", 32'(out_sum), 32'(es));
      check("lit_carry", 32'(out_carry), 32'(ec));
      check("model_sum", 32'(m_sum), 32'(es));
      check("model_carry", 32'(m_carry), 32'(ec));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_sum", 32'(out_sum), 32'(es));
         check("hold_carry", 32'(out_carry), 32'(ec));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_ready", 32'(in_ready), 32'd1);
      check("post_hs_sum", 32'(out_sum), 32'(es));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int r0;
      int a0;
      int n0;
      int cyc;
      logic saw_valid;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sum", 32'(out_sum), 32'd0);
      check("rst_carry", 32'(out_carry), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // First accept on the first edge after release.
      rst_n = 1'b1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);
      start_op(16'h1234, 16'h4321);
      finish_op(16'h5555, 1'b0, 0);

      start_op(16'h0001, 16'hFFFF);
      finish_op(16'h0000, 1'b1, 0);

      out_ready = 1'b0;
      start_op(16'h8000, 16'h8000);
      finish_op(16'h0000, 1'b1, 10);

      // Back-to-back with in_valid held high and operands churning in RUN.
      out_ready = 1'b1;
      r0 = res_q.size();
      a0 = dut_acc_q.size();
      n0 = n_acc;
      in_a     = 16'h00FF;
      in_b     = 16'h0001;
      in_valid = 1'b1;
      for (int k = 0; k < 40 && n_acc < n0 + 2; k++) begin
         @(posedge clk);
         #1;
         if (n_acc == n0 + 1) begin
            if (!m_pend && !m_valid) begin
               in_a = 16'h0F0F;
               in_b = 16'hF0F0;
            end else begin
               in_a = W'($urandom);
               in_b = W'($urandom);
            end
         end
      end
      in_valid = 1'b0;
      for (int k = 0; k < 30 && res_q.size() < r0 + 2; k++) @(negedge clk);
      check("b2b_count", 32'(res_q.size() - r0), 32'd2);
      check("b2b_acc_count", 32'(dut_acc_q.size() - a0), 32'd2);
      if (res_q.size() >= r0 + 2) begin
         check("b2b_res0", 32'(res_q[r0]), 32'h0_0100);
         check("b2b_res1", 32'(res_q[r0 + 1]), 32'h0_FFFF);
      end
      if (dut_acc_q.size() >= a0 + 2)
         check("b2b_interval", 32'(dut_acc_q[a0 + 1] - dut_acc_q[a0]), 32'(NIBBLES + 2));

      // Asynchronous reset on the second RUN cycle.
      @(negedge clk);
      in_a     = 16'h1111;
      in_b     = 16'h2222;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sum", 32'(out_sum), 32'd0);
      check("arst_carry", 32'(out_carry), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("no_spurious_valid", 32'(saw_valid), 32'd0);
      start_op(16'h0002, 16'h0003);
      finish_op(16'h0005, 1'b0, 0);

      // Randomised run against the model.
      n0  = n_acc;
      cyc = 0;
      while (n_acc < n0 + 1000 && cyc < 40000) begin
         @(posedge clk);
         #1;
         cyc++;
         in_valid  = ($urandom_range(0, 1) == 1);
         in_a      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
         in_b      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      check("random_done", 32'(n_acc - n0 >= 1000), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
